// File: rtl/vx_imem_responder.sv
// Instruction-memory responder: byte-writable word array with fixed-latency reads,
// credit-based flow control and a response FIFO that the read pipeline falls through.
// Optional IMEM_BOUNDS_CHECK_EN: out-of-range reads return 0, out-of-range writes are dropped, err is set.
module vx_imem_responder #(
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    parameter int SIZE       = 1024,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_byteen,
    input  logic [31:0]           req_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  err
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [31:0]          mem [SIZE];
    logic [LATENCY-1:0]   pipe_valid;
    logic [31:0]          pipe_data [LATENCY];
    logic [TAG_WIDTH-1:0] pipe_tag  [LATENCY];
    logic [31:0]          fifo_data [RSP_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag  [RSP_DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     fifo_count, credits;

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic [31:0]      rd_word;
    logic             rd_accept, wr_accept;
    logic             pipe_out_valid, fifo_empty;
    logic             pop, fifo_pop, push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign idx = IDX_W'(req_addr % ADDR_WIDTH'(SIZE));

`ifdef IMEM_BOUNDS_CHECK_EN
    assign in_range = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(SIZE));
`else
    assign in_range = 1'b1;
`endif

    // Writes never need a credit; reads need one so the FIFO can always absorb the pipeline.
    assign req_ready = !reset && ((credits != '0) || req_rw);
    assign rd_accept = req_valid && req_ready && !req_rw;
    assign wr_accept = req_valid && req_ready && req_rw;
    assign rd_word   = in_range ? mem[idx] : 32'h0;

    // NOTE: the memory array and data-path registers carry no reset; only valid bits and counters do.
    always_ff @(posedge clk) begin
        if (wr_accept && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (req_byteen[b]) mem[idx][8*b +: 8] <= req_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_accept;
            for (int k = 1; k < LATENCY; k++) pipe_valid[k] <= pipe_valid[k-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= rd_word;
        pipe_tag[0]  <= req_tag;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_data[k] <= pipe_data[k-1];
            pipe_tag[k]  <= pipe_tag[k-1];
        end
    end

    // An empty FIFO is bypassed: the pipeline head is presented directly and only
    // enqueued when the consumer does not take it, so the word stays stable.
    assign pipe_out_valid = pipe_valid[LATENCY-1];
    assign fifo_empty     = (fifo_count == '0);
    assign rsp_valid      = !fifo_empty || pipe_out_valid;
    assign rsp_data       = fifo_empty ? pipe_data[LATENCY-1] : fifo_data[rd_ptr];
    assign rsp_tag        = fifo_empty ? pipe_tag[LATENCY-1]  : fifo_tag[rd_ptr];
    assign pop            = rsp_valid && rsp_ready;
    assign fifo_pop       = pop && !fifo_empty;
    assign push           = pipe_out_valid && !(fifo_empty && rsp_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
            fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            credits    <= CNT_W'(RSP_DEPTH);
        end else begin
            if (push)     wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({rd_accept, pop})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

`ifdef IMEM_BOUNDS_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((rd_accept || wr_accept) && !in_range) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
